// File: rtl/alu_multicycle.sv
// Handshaked execute-stage ALU: single-cycle logic/add ops plus iterative
// unsigned multiply, divide and remainder that take WIDTH busy cycles.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_GTU  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;
  localparam logic [3:0] OP_REMU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               overflow_reg;
  logic               div_zero_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_mul_reg;
  logic               is_rem_reg;
  // MUL: opa = shifted multiplicand, opb = shifted multiplier, acc = partial product.
  // DIV: opa = dividend shifting into quotient, opb = divisor, acc = partial remainder.
  logic [WIDTH-1:0]   opa_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic [WIDTH-1:0]   acc_reg;

  logic [WIDTH-1:0]   sc_out;
  logic               sc_ov;
  logic               sc_dz;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               op_is_div;
  logic               is_iter;

  logic [WIDTH-1:0]   mul_acc_next;
  logic [WIDTH:0]     rem_shift;
  logic               rem_fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   q_next;

  always_comb begin
    sum       = operand_1 + operand_2;
    diff      = operand_1 - operand_2;
    sc_out    = '0;
    sc_ov     = 1'b0;
    sc_dz     = 1'b0;
    op_is_div = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
    is_iter   = (alu_op == OP_MUL) || (op_is_div && (operand_2 != '0));
    case (alu_op)
      OP_AND: sc_out = operand_1 & operand_2;
      OP_OR:  sc_out = operand_1 | operand_2;
      OP_NOR: sc_out = ~(operand_1 | operand_2);
      OP_GTU: sc_out = {{(WIDTH-1){1'b0}}, (operand_1 > operand_2)};
      OP_ADD: begin
        sc_out = sum;
        sc_ov  = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                 (sum[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_out = diff;
        sc_ov  = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                 (diff[WIDTH-1] != operand_1[WIDTH-1]);
      end
      // Only reached here with a zero divisor; nonzero divisors iterate.
      OP_DIVU: begin
        sc_out = '1;
        sc_dz  = 1'b1;
      end
      OP_REMU: begin
        sc_out = operand_1;
        sc_dz  = 1'b1;
      end
      default: sc_out = '0;
    endcase
  end

  always_comb begin
    mul_acc_next = acc_reg + (opb_reg[0] ? opa_reg : '0);
    rem_shift    = {acc_reg, opa_reg[WIDTH-1]};
    rem_fits     = rem_shift >= {1'b0, opb_reg};
    // True difference is below the divisor, so WIDTH bits cannot wrap.
    rem_next     = rem_fits ? (rem_shift[WIDTH-1:0] - opb_reg) : rem_shift[WIDTH-1:0];
    q_next       = {opa_reg[WIDTH-2:0], rem_fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_reg       <= '0;
      overflow_reg  <= 1'b0;
      div_zero_reg  <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      is_mul_reg    <= 1'b0;
      is_rem_reg    <= 1'b0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      acc_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            if (is_iter) begin
              opa_reg    <= operand_1;
              opb_reg    <= operand_2;
              acc_reg    <= '0;
              cnt_reg    <= CNT_W'(WIDTH);
              is_mul_reg <= (alu_op == OP_MUL);
              is_rem_reg <= (alu_op == OP_REMU);
              state_reg  <= BUSY;
            end else begin
              out_reg       <= sc_out;
              overflow_reg  <= sc_ov;
              div_zero_reg  <= sc_dz;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (is_mul_reg) begin
            acc_reg <= mul_acc_next;
            opa_reg <= opa_reg << 1;
            opb_reg <= opb_reg >> 1;
          end else begin
            acc_reg <= rem_next;
            opa_reg <= q_next;
          end
          if (cnt_reg == CNT_W'(1)) begin
            out_reg       <= is_mul_reg ? mul_acc_next : (is_rem_reg ? rem_next : q_next);
            overflow_reg  <= 1'b0;
            div_zero_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign zero      = (out_reg == '0);
  assign overflow  = overflow_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized + directed bench for alu_multicycle at WIDTH=32 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid32, in_valid8;
  logic [3:0]  alu_op;
  logic [31:0] opa, opb;
  logic        out_ready;

  logic        in_ready32, out_valid32, zero32, ov32, dz32;
  logic [31:0] out32;
  logic        in_ready8, out_valid8, zero8, ov8, dz8;
  logic [7:0]  out8;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .alu_op(alu_op), .operand_1(opa), .operand_2(opb),
    .out_valid(out_valid32), .out_ready(out_ready), .out(out32),
    .zero(zero32), .overflow(ov32), .div_zero(dz32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_op(alu_op), .operand_1(opa[7:0]), .operand_2(opb[7:0]),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8),
    .zero(zero8), .overflow(ov8), .div_zero(dz8)
  );

  logic        sel8;
  logic        cur_in_ready, cur_out_valid, cur_zero, cur_ov, cur_dz;
  logic [31:0] cur_out;
  assign cur_in_ready  = sel8 ? in_ready8  : in_ready32;
  assign cur_out_valid = sel8 ? out_valid8 : out_valid32;
  assign cur_zero      = sel8 ? zero8      : zero32;
  assign cur_ov        = sel8 ? ov8        : ov32;
  assign cur_dz        = sel8 ? dz8        : dz32;
  assign cur_out       = sel8 ? {24'd0, out8} : out32;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s w=%0d got=%0h exp=%0h", tag, sel8 ? 8 : 32, got, exp);
    end
  endtask

  // Reference: results straight from the op definitions, masked to w bits.
  function automatic void model(input logic [3:0] op, input longint unsigned a_in,
                                input longint unsigned b_in, input int w,
                                output longint unsigned r, output bit ov, output bit dz);
    longint unsigned mask, a, b, sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = (a >> (w - 1)) & 64'd1;
    sb = (b >> (w - 1)) & 64'd1;
    r = 0; ov = 0; dz = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin r = (a + b) & mask; sr = (r >> (w - 1)) & 64'd1; ov = (sa == sb) && (sr != sa); end
      4'd6:  begin r = (a - b) & mask; sr = (r >> (w - 1)) & 64'd1; ov = (sa != sb) && (sr != sa); end
      4'd7:  r = (a > b) ? 64'd1 : 64'd0;
      4'd12: r = ~(a | b) & mask;
      4'd3:  r = (a * b) & mask;
      4'd8:  if (b == 0) begin r = mask; dz = 1; end else r = a / b;
      4'd9:  if (b == 0) begin r = a; dz = 1; end else r = a % b;
      default: r = 0;
    endcase
  endfunction

  task automatic set_valid(input bit v);
    if (sel8) in_valid8 = v; else in_valid32 = v;
  endtask

  task automatic do_op(input bit s8, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int w, lat, exp_lat;
    longint unsigned er, mask;
    bit eov, edz, multi, busy_ok, stable_ok;
    w = s8 ? 8 : 32;
    mask = (64'd1 << w) - 64'd1;
    model(op, a, b, w, er, eov, edz);
    multi = (op == 4'd3) || (((op == 4'd8) || (op == 4'd9)) && ((b & mask) != 0));
    exp_lat = multi ? w + 1 : 1;
    @(negedge clk);
    sel8 = s8; alu_op = op; opa = a; opb = b;
    set_valid(1'b1);
    #1 check("in_ready_idle", 64'(cur_in_ready), 64'd1);
    @(posedge clk); #1;
    set_valid(1'b0);
    opa = $urandom; opb = $urandom; alu_op = 4'($urandom);
    lat = 1; busy_ok = 1;
    while (!cur_out_valid && lat < 200) begin
      if (cur_in_ready) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    if (multi) check("busy_in_ready", 64'(busy_ok), 64'd1);
    check("done_in_ready", 64'(cur_in_ready), 64'd0);
    check("out", 64'(cur_out), er);
    check("overflow", 64'(cur_ov), 64'(eov));
    check("div_zero", 64'(cur_dz), 64'(edz));
    check("zero", 64'(cur_zero), 64'(er == 0));
    $display("txn w=%0d op=%b a=%h b=%h out=%h ov=%0d dz=%0d lat=%0d",
             w, op, a & 32'(mask), b & 32'(mask), cur_out, cur_ov, cur_dz, lat);
    stable_ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      opa = $urandom; opb = $urandom; alu_op = 4'($urandom);
      set_valid(1'($urandom));
      @(posedge clk); #1;
      if (!cur_out_valid || cur_in_ready || cur_out !== 32'(er) ||
          cur_ov !== eov || cur_dz !== edz) stable_ok = 0;
    end
    if (hold > 0) check("hold_stable", 64'(stable_ok), 64'd1);
    @(negedge clk);
    set_valid(1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 64'(cur_out_valid), 64'd0);
    check("release_ready", 64'(cur_in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_mul(input bit s8);
    bit quiet;
    int w;
    w = s8 ? 8 : 32;
    @(negedge clk);
    sel8 = s8; alu_op = 4'd3; opa = 32'h0001_2345; opb = 32'h0000_0103;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_out", 64'(cur_out), 64'd0);
    check("rst_zero", 64'(cur_zero), 64'd1);
    check("rst_out_valid", 64'(cur_out_valid), 64'd0);
    check("rst_in_ready", 64'(cur_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1;
    repeat (w + 4) begin
      @(posedge clk); #1;
      if (cur_out_valid) quiet = 0;
    end
    check("rst_discard", 64'(quiet), 64'd1);
    do_op(s8, 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 0);
  endtask

  localparam int NOPS = 12;
  logic [3:0] op_tab [NOPS] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12,
                                 4'd3, 4'd8, 4'd9, 4'd4, 4'd5, 4'd15};

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    rst = 1'b1; in_valid32 = 0; in_valid8 = 0; out_ready = 0;
    alu_op = 0; opa = 0; opb = 0; sel8 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out32", 64'(out32), 64'd0);
    check("reset_zero32", 64'(zero32), 64'd1);
    check("reset_flags32", 64'({ov32, dz32}), 64'd0);
    check("reset_hs32", 64'({in_ready32, out_valid32}), 64'b10);
    check("reset_out8", 64'(out8), 64'd0);
    check("reset_hs8", 64'({in_ready8, out_valid8}), 64'b10);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      do_op(1'(s), 4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 0);
      do_op(1'(s), 4'd2,  32'h0000_007F, 32'h0000_0001, 0);
      do_op(1'(s), 4'd6,  32'd5, 32'd5, 0);
      do_op(1'(s), 4'd6,  32'h8000_0000, 32'h0000_0001, 0);
      do_op(1'(s), 4'd7,  32'hFFFF_FFFF, 32'd1, 0);
      do_op(1'(s), 4'd3,  32'h0001_2345, 32'h0000_0100, 0);
      do_op(1'(s), 4'd3,  32'hFFFF_FFFF, 32'd2, 0);
      do_op(1'(s), 4'd8,  32'd100, 32'd7, 0);
      do_op(1'(s), 4'd9,  32'd100, 32'd7, 0);
      do_op(1'(s), 4'd8,  32'd9, 32'd0, 0);
      do_op(1'(s), 4'd9,  32'd9, 32'd0, 0);
      do_op(1'(s), 4'd8,  32'hFFFF_FFFF, 32'd1, 0);
      do_op(1'(s), 4'd15, 32'h1234_5678, 32'h1, 0);
      do_op(1'(s), 4'd3,  32'h0000_0033, 32'h0000_0011, 10);
      do_op(1'(s), 4'd2,  32'h8000_0000, 32'h8000_0000, 10);
      for (int i = 0; i < 40; i++) begin
        rop = op_tab[$urandom_range(0, NOPS - 1)];
        ra = $urandom;
        rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
        do_op(1'(s), rop, ra, rb, $urandom_range(0, 3));
      end
      reset_mid_mul(1'(s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the single-cycle ALU; sits in the execute stage.
- Keeps the existing 4-bit op encoding and the registered result.
- Adds iterative unsigned multiply, divide and remainder, signed-overflow and divide-by-zero flags.
- Uses valid/ready handshakes on input and output, so the control unit can stall on multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept an op (high only in IDLE).
- alu_op  input  4  operation select.
- operand_1  input  WIDTH  operand A.
- operand_2  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  registered result.
- zero  output  1  (out == 0), combinational from the out register.
- overflow  output  1  signed overflow of ADD/SUB, registered.
- div_zero  output  1  DIVU/REMU with operand_2 == 0, registered.

Behaviour:
- Op encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 GTU: 1 if A>B unsigned, else 0.
  - 1100 NOR.
  - 0011 MUL: low WIDTH bits of unsigned A*B.
  - 1000 DIVU: unsigned quotient.
  - 1001 REMU: unsigned remainder.
  - Any other code: out = 0, flags 0, single-cycle.
- All arithmetic wraps modulo 2^WIDTH.
- overflow is set only for ADD/SUB:
  - ADD: sign(A)==sign(B) and sign(out)!=sign(A).
  - SUB: sign(A)!=sign(B) and sign(out)!=sign(A).
- FSM states: IDLE, BUSY, DONE. Accept = in_valid && in_ready.
- IDLE:
  - On accept of a single-cycle op, compute the result and register it into out/flags at the same edge; go to DONE.
  - On accept of MUL/DIVU/REMU with operand_2 != 0 (or any MUL), latch operands, clear the accumulator, load counter = WIDTH; go to BUSY.
  - On accept of DIVU/REMU with operand_2 == 0: out = all-ones for DIVU, out = A for REMU, div_zero = 1; go to DONE (no BUSY).
- BUSY:
  - One iteration per cycle: shift-add for MUL, restoring shift-subtract for DIVU/REMU; counter decrements.
  - When the counter reaches 1, write the final result into out at that edge; go to DONE.
  - BUSY lasts exactly WIDTH cycles.
  - in_valid is ignored while busy; operands latched at accept are used, so later input changes have no effect.
- DONE:
  - out_valid = 1; out and flags are held stable until out_ready.
  - out_ready in DONE -> IDLE at the next edge.
  - in_ready is 0 in DONE; there is no same-cycle pass-through.
- Latency, from accept edge to first cycle of out_valid:
  - Single-cycle ops and div-by-zero: 1 edge.
  - MUL/DIVU/REMU: WIDTH+1 edges.
- Throughput: at most one op per 2 cycles (single-cycle ops with out_ready tied high).
- out, overflow and div_zero change only on the edge entering DONE; they hold their values in IDLE/BUSY until the next DONE.
- Reset (any time, including mid-BUSY):
  - state = IDLE, out = 0 (so zero = 1), overflow = 0, div_zero = 0, counter = 0.
  - in_ready = 1, out_valid = 0.
  - Any in-flight op is discarded; no out_valid is produced for it.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF B=0x00000001 -> out_valid 1 edge after accept, out=0x80000000, overflow=1, zero=0.
- SUB A=5 B=5 -> out=0, zero=1, overflow=0; then GTU A=0xFFFFFFFF B=1 -> out=1.
- MUL A=0x00012345 B=0x00000100 -> in_ready low for 32 cycles, out_valid at edge 33, out=0x01234500.
  - Also check MUL A=0xFFFFFFFF B=2 -> out=0xFFFFFFFE.
- DIVU A=100 B=7 -> out=14 at edge 33; REMU A=100 B=7 -> out=2.
  - DIVU A=9 B=0 -> out=0xFFFFFFFF, div_zero=1 after 1 edge.
  - REMU A=9 B=0 -> out=9, div_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out/flags stable, in_valid pulses ignored; raise out_ready -> IDLE next edge.
- Assert rst at cycle 10 of a MUL -> out=0, zero=1, out_valid=0, in_ready=1 immediately.
  - After release, a new AND 0xF0F0 & 0xFF00 -> 0xF000.
  - Repeat the suite with WIDTH=8.
